// File: rtl/io_pkg.sv
// io_pkg: register offsets and bus base address for the board input peripheral
package io_pkg;
  localparam logic [1:0] IO_SW_STATE  = 2'd0;
  localparam logic [1:0] IO_KEY_STATE = 2'd1;
  localparam logic [1:0] IO_KEY_EDGE  = 2'd2;
  localparam logic [1:0] IO_KEY_IE    = 2'd3;
  localparam logic [31:0] IO_BASE_ADDR = 32'h0000_2000;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-FF synchroniser plus stable-count debounce for one raw pin; d is normalised so 0 = idle
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE            = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic d
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, s;
  logic [CW-1:0] c;
  // XOR with the idle level makes active-low pins read 1 when asserted
  assign s = s2 ^ IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= IDLE;
      s2 <= IDLE;
      c  <= '0;
      d  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      c  <= (s == d || c == C_LAST) ? '0 : c + 1'b1;
      d  <= (s != d && c == C_LAST) ? s : d;
    end
  end
endmodule

// File: rtl/io_input_port.sv
// io_input_port: debounced switches/buttons with latched press events, readable over a word-addressed bus
module io_input_port
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = 10,
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  SW,
  input  logic [KEY_WIDTH-1:0] KEY,
  input  logic [1:0]           addr,
  input  logic                 wr_en,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 irq
);
  logic [SW_WIDTH-1:0]  d_sw;
  logic [KEY_WIDTH-1:0] d_key, d_key_q, key_edge, key_ie, clr;
  logic                 unused_wdata;
  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b0)) u_db (
      .clk(clk), .reset(reset), .raw(SW[i]), .d(d_sw[i])
    );
  end
  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b1)) u_db (
      .clk(clk), .reset(reset), .raw(KEY[i]), .d(d_key[i])
    );
  end
  assign unused_wdata = ^wdata[31:KEY_WIDTH];
  assign clr = (wr_en && addr == IO_KEY_EDGE) ? wdata[KEY_WIDTH-1:0] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      d_key_q  <= '0;
      key_edge <= '0;
      key_ie   <= '0;
    end else begin
      d_key_q  <= d_key;
      // new presses are OR-ed in after the clear so a coincident press survives
      key_edge <= (key_edge & ~clr) | (d_key & ~d_key_q);
      key_ie   <= (wr_en && addr == IO_KEY_IE) ? wdata[KEY_WIDTH-1:0] : key_ie;
    end
  end
  always_comb begin
    rdata = (addr == IO_SW_STATE)  ? 32'(d_sw) :
            (addr == IO_KEY_STATE) ? 32'(d_key) :
            (addr == IO_KEY_EDGE)  ? 32'(key_edge) : 32'(key_ie);
  end
  assign irq = |(key_edge & key_ie);
endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed vectors for io_input_port with DEBOUNCE_CYCLES=4
module tb_io_input_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [1:0]  addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  int checks = 0;
  int errors = 0;

  io_input_port #(.SW_WIDTH(10), .KEY_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .SW(SW), .KEY(KEY), .addr(addr),
    .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    addr  = a;
    wdata = v;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; SW = '0; KEY = 4'hF; addr = '0; wr_en = 1'b0; wdata = '0;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      rd("rst_sw", 2'd0, 32'h0);
      rd("rst_key", 2'd1, 32'h0);
      rd("rst_edge", 2'd2, 32'h0);
      rd("rst_ie", 2'd3, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
    end

    SW = 10'h2A5;
    for (int k = 1; k <= 8; k++) begin
      step();
      rd("sw_accept", 2'd0, k >= 6 ? 32'h2A5 : 32'h0);
    end

    KEY = 4'b1101;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) KEY = 4'hF;
      step();
      rd("glitch_key", 2'd1, 32'h0);
      rd("glitch_edge", 2'd2, 32'h0);
    end

    wr(2'd3, 32'h4);
    rd("ie_wr", 2'd3, 32'h4);
    KEY = 4'b1011;
    repeat (10) step();
    rd("press_key", 2'd1, 32'h4);
    rd("press_edge", 2'd2, 32'h4);
    check("press_irq", {31'b0, irq}, 32'h1);
    KEY = 4'hF;
    repeat (8) step();
    rd("release_key", 2'd1, 32'h0);
    rd("release_edge", 2'd2, 32'h4);
    wr(2'd2, 32'h4);
    rd("clr_edge", 2'd2, 32'h0);
    check("clr_irq", {31'b0, irq}, 32'h0);

    KEY = 4'b0111;
    repeat (6) step();
    rd("sim_key", 2'd1, 32'h8);
    rd("sim_edge_pre", 2'd2, 32'h0);
    wr(2'd2, 32'h8);
    rd("sim_edge", 2'd2, 32'h8);
    KEY = 4'hF;
    repeat (8) step();

    wr(2'd3, 32'h0);
    KEY = 4'b1110;
    repeat (10) step();
    rd("dis_key", 2'd1, 32'h1);
    rd("dis_edge", 2'd2, 32'h9);
    check("dis_irq", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h8);
    check("en_irq", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    rd("clr_iso", 2'd2, 32'h8);
    check("clr_iso_irq", {31'b0, irq}, 32'h1);
    KEY = 4'hF;
    repeat (8) step();

    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd("ro_sw", 2'd0, 32'h2A5);
    rd("ro_key", 2'd1, 32'h0);

    SW = 10'h155;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd("mrst_sw", 2'd0, 32'h0);
    rd("mrst_edge", 2'd2, 32'h0);
    rd("mrst_ie", 2'd3, 32'h0);
    check("mrst_irq", {31'b0, irq}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      rd("mrst_accept", 2'd0, k >= 6 ? 32'h155 : 32'h0);
    end

    wr(2'd3, 32'hFFFF_FFFF);
    rd("ie_upper", 2'd3, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
